// File: rtl/idli_pkg.sv
// Shared types and constants for the SQI link (mode, command codes, responder states).
// IDLI_SQIM_RDMR_EN enables the read-mode-register command in the responder.
package idli_pkg;

  typedef enum logic {
    SQI_MODE_OUT = 1'b0,
    SQI_MODE_IN  = 1'b1
  } sqi_mode_t;

  localparam logic [7:0] SQIM_CMD_WRITE  = 8'h02;
  localparam logic [7:0] SQIM_CMD_READ   = 8'h03;
  localparam logic [7:0] SQIM_CMD_RDMR   = 8'h05;
  localparam logic [7:0] SQIM_RDMR_VALUE = 8'h40;

  typedef enum logic [2:0] {
    SQIM_IDLE,
    SQIM_CMD,
    SQIM_ADDR,
    SQIM_DUMMY,
    SQIM_RDATA,
    SQIM_WDATA,
    SQIM_SKIP
  } sqim_state_t;

endpackage

// File: rtl/idli_sqi_mem_edge_m.sv
// SCK edge detector: SCK is sampled as an ordinary signal in the gck domain and
// turned into single-cycle rise/fall strobes.
module idli_sqi_mem_edge_m (
  input  logic gck,
  input  logic rst,
  input  logic sck,
  output logic sck_rise,
  output logic sck_fall
);

  logic sck_q;

  always_ff @(posedge gck) begin
    if (rst) sck_q <= 1'b0;
    else     sck_q <= sck;
  end

  assign sck_rise = sck & ~sck_q;
  assign sck_fall = ~sck & sck_q;

endmodule

// File: rtl/idli_sqi_mem_m.sv
// SQI SRAM responder: decodes command/address nibbles, serves sequential reads and writes.
// Optional IDLI_SQIM_RDMR_EN adds command 0x05 returning the sequential-mode register.
//
//  state  | meaning
//  IDLE   | waiting for first rise with cs low
//  CMD    | low command nibble pending
//  ADDR   | shifting four address nibbles
//  DUMMY  | DUMMY_NIBS ignored nibbles before read data
//  RDATA  | presenting read nibbles on each fall
//  WDATA  | collecting write nibbles, byte written on low nibble
//  SKIP   | unknown command, idle until cs high
module idli_sqi_mem_m
  import idli_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int DUMMY_NIBS  = 2
) (
  input  logic       i_sqim_gck,
  input  logic       i_sqim_rst,
  input  logic       i_sqim_sck,
  input  logic       i_sqim_cs,
  input  sqi_mode_t  i_sqim_mode,
  input  logic [3:0] i_sqim_data,
  output logic [3:0] o_sqim_data,
  output logic       o_sqim_data_oe,
  output logic       o_sqim_err
);

  localparam int         ADDR_W     = $clog2(DEPTH_BYTES);
  localparam logic [1:0] DUMMY_LAST = 2'(DUMMY_NIBS - 1);

  sqim_state_t state_q, state_d;
  logic        sck_rise, sck_fall;
  logic        cs_q;
  logic [1:0]  cnt_q;
  logic [7:0]  cmd_q;
  logic [15:0] addr_q;
  logic [3:0]  wr_hi_q;
  logic        err_set;
  logic [7:0]  cmd_full;
  logic [7:0]  rd_byte;
  logic        is_wr;
  logic [7:0]  mem [DEPTH_BYTES];

  idli_sqi_mem_edge_m u_edge (
    .gck      (i_sqim_gck),
    .rst      (i_sqim_rst),
    .sck      (i_sqim_sck),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  assign cmd_full = {cmd_q[3:0], i_sqim_data};
  assign is_wr    = (cmd_q == SQIM_CMD_WRITE);

`ifdef IDLI_SQIM_RDMR_EN
  assign rd_byte = (cmd_q == SQIM_CMD_RDMR) ? SQIM_RDMR_VALUE : mem[addr_q[ADDR_W-1:0]];
`else
  assign rd_byte = mem[addr_q[ADDR_W-1:0]];
`endif

  assign o_sqim_data_oe = (state_q == SQIM_RDATA) & ~i_sqim_cs & (i_sqim_mode == SQI_MODE_IN);

  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    if (i_sqim_cs) begin
      state_d = SQIM_IDLE;
      // a rise landing in the very cycle cs deasserts is dropped but flagged
      err_set = sck_rise & ~cs_q;
    end else begin
      if (state_q == SQIM_RDATA && i_sqim_mode != SQI_MODE_IN) err_set = 1'b1;
      if (sck_rise) begin
        case (state_q)
          SQIM_IDLE: state_d = SQIM_CMD;
          SQIM_CMD: begin
            case (cmd_full)
              SQIM_CMD_READ, SQIM_CMD_WRITE: state_d = SQIM_ADDR;
`ifdef IDLI_SQIM_RDMR_EN
              SQIM_CMD_RDMR: state_d = SQIM_RDATA;
`endif
              default: begin
                state_d = SQIM_SKIP;
                err_set = 1'b1;
              end
            endcase
          end
          SQIM_ADDR: begin
            if (cnt_q == 2'd3) begin
              if (is_wr)                state_d = SQIM_WDATA;
              else if (DUMMY_NIBS == 0) state_d = SQIM_RDATA;
              else                      state_d = SQIM_DUMMY;
            end
          end
          SQIM_DUMMY: if (cnt_q == DUMMY_LAST) state_d = SQIM_RDATA;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_sqim_gck) begin
    if (i_sqim_rst) begin
      state_q     <= SQIM_IDLE;
      cs_q        <= 1'b1;
      cnt_q       <= 2'd0;
      cmd_q       <= 8'h00;
      addr_q      <= 16'h0000;
      wr_hi_q     <= 4'h0;
      o_sqim_data <= 4'h0;
      o_sqim_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      cs_q    <= i_sqim_cs;
      if (err_set) o_sqim_err <= 1'b1;
      if (!i_sqim_cs && sck_rise) begin
        case (state_q)
          SQIM_IDLE: cmd_q <= cmd_full;
          SQIM_CMD: begin
            cmd_q <= cmd_full;
            cnt_q <= 2'd0;
          end
          SQIM_ADDR: begin
            addr_q <= {addr_q[11:0], i_sqim_data};
            cnt_q  <= cnt_q + 2'd1;
          end
          SQIM_DUMMY: cnt_q <= (cnt_q == DUMMY_LAST) ? 2'd0 : cnt_q + 2'd1;
          SQIM_WDATA: begin
            if (!cnt_q[0]) wr_hi_q <= i_sqim_data;
            else           addr_q  <= addr_q + 16'd1;
            cnt_q <= {1'b0, ~cnt_q[0]};
          end
          default: ;
        endcase
      end
      if (!i_sqim_cs && sck_fall && state_q == SQIM_RDATA) begin
        o_sqim_data <= cnt_q[0] ? rd_byte[3:0] : rd_byte[7:4];
        if (cnt_q[0]) addr_q <= addr_q + 16'd1;
        cnt_q <= {1'b0, ~cnt_q[0]};
      end
    end
  end

  // storage is deliberately left unreset
  always_ff @(posedge i_sqim_gck) begin
    if (!i_sqim_rst && !i_sqim_cs && sck_rise && state_q == SQIM_WDATA && cnt_q[0])
      mem[addr_q[ADDR_W-1:0]] <= {wr_hi_q, i_sqim_data};
  end

endmodule
